// File: rtl/master_to_slave_mux.sv
// AHB request-path multiplexer: steers the granted master's address phase to the
// slaves, tracks the data-phase owner for HWDATA, and follows burst beats.
module master_to_slave_mux #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              Hclk,
  input  logic                              Hresetn,
  input  logic [MW-1:0]                     Hmaster,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] Haddr_M,
  input  logic [NUM_MASTERS*2-1:0]          Htrans_M,
  input  logic [NUM_MASTERS-1:0]            Hwrite_M,
  input  logic [NUM_MASTERS*3-1:0]          Hsize_M,
  input  logic [NUM_MASTERS*3-1:0]          Hburst_M,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] Hwdata_M,
  input  logic                              Hready,
  output logic [ADDR_WIDTH-1:0]             Haddr,
  output logic [1:0]                        Htrans,
  output logic                              Hwrite,
  output logic [2:0]                        Hsize,
  output logic [2:0]                        Hburst,
  output logic [DATA_WIDTH-1:0]             Hwdata,
  output logic [MW-1:0]                     Hmaster_data,
  output logic                              data_active,
  output logic                              data_write,
  output logic [4:0]                        beat_idx,
  output logic                              burst_last,
  output logic                              seq_err
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic [4:0] beat_cnt;
  logic [4:0] burst_len;
  logic       in_burst;
  logic [4:0] live_len;
  logic [4:0] cur_len;
  logic       seq_viol;
  htrans_e    cur_trans;

  // 0 means undefined length (INCR); no beat of such a burst is ever "last".
  function automatic logic [4:0] burst_len_of(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      3'b000:         len = 5'd1;
      3'b001:         len = 5'd0;
      3'b010, 3'b011: len = 5'd4;
      3'b100, 3'b101: len = 5'd8;
      default:        len = 5'd16;
    endcase
    return len;
  endfunction

  // An out-of-range grant matches no slot and leaves the bus IDLE with zeros.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    Haddr  = '0;
    Htrans = TR_IDLE;
    Hwrite = 1'b0;
    Hsize  = '0;
    Hburst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (Hmaster == MW'(i)) begin
        Haddr  = Haddr_M[i*ADDR_WIDTH +: ADDR_WIDTH];
        Htrans = Htrans_M[i*2 +: 2];
        Hwrite = Hwrite_M[i];
        Hsize  = Hsize_M[i*3 +: 3];
        Hburst = Hburst_M[i*3 +: 3];
      end
    end
  end

  // Write data follows the registered data-phase owner, not the live grant.
  always_comb begin
    Hwdata = '0;
    if (data_active && data_write) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (Hmaster_data == MW'(i)) Hwdata = Hwdata_M[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    cur_trans  = htrans_e'(Htrans);
    live_len   = burst_len_of(Hburst);
    cur_len    = (cur_trans == TR_NONSEQ) ? live_len : burst_len;
    beat_idx   = (cur_trans == TR_NONSEQ) ? 5'd0 : beat_cnt;
    burst_last = Htrans[1] && (cur_len != 5'd0) && (beat_idx == cur_len - 5'd1);
    seq_viol   = (((cur_trans == TR_SEQ) || (cur_trans == TR_BUSY)) && !in_burst) ||
                 ((cur_trans == TR_SEQ) && (burst_len != 5'd0) && (beat_cnt >= burst_len));
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Hmaster_data <= '0;
      data_active  <= 1'b0;
      data_write   <= 1'b0;
      beat_cnt     <= '0;
      burst_len    <= '0;
      in_burst     <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      seq_err <= Hready && seq_viol;
      if (Hready) begin
        Hmaster_data <= Hmaster;
        data_active  <= Htrans[1];
        data_write   <= Hwrite && Htrans[1];
        case (cur_trans)
          TR_NONSEQ: begin
            beat_cnt  <= 5'd1;
            burst_len <= live_len;
            in_burst  <= (live_len != 5'd1);
          end
          TR_SEQ: begin
            beat_cnt <= (beat_cnt == 5'd31) ? beat_cnt : beat_cnt + 5'd1;
            if (burst_last) in_burst <= 1'b0;
          end
          TR_IDLE: begin
            beat_cnt <= '0;
            in_burst <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_master_to_slave_mux.sv
// Self-checking bench for master_to_slave_mux: directed plan sequences, a burst
// vector table, and randomized traffic against a behavioural bus model.
module tb_master_to_slave_mux;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 2;

  logic          Hclk = 1'b0;
  logic          Hresetn;
  logic [MW-1:0] Hmaster;
  logic          Hready;
  logic [AW-1:0] addr_m  [NM];
  logic [1:0]    trans_m [NM];
  logic          write_m [NM];
  logic [2:0]    size_m  [NM];
  logic [2:0]    burst_m [NM];
  logic [DW-1:0] wdata_m [NM];

  logic [NM*AW-1:0] Haddr_M;
  logic [NM*2-1:0]  Htrans_M;
  logic [NM-1:0]    Hwrite_M;
  logic [NM*3-1:0]  Hsize_M;
  logic [NM*3-1:0]  Hburst_M;
  logic [NM*DW-1:0] Hwdata_M;

  logic [AW-1:0] Haddr;
  logic [1:0]    Htrans;
  logic          Hwrite;
  logic [2:0]    Hsize, Hburst;
  logic [DW-1:0] Hwdata;
  logic [MW-1:0] Hmaster_data;
  logic          data_active, data_write, burst_last, seq_err;
  logic [4:0]    beat_idx;

  for (genvar g = 0; g < NM; g++) begin : g_pack
    assign Haddr_M[g*AW +: AW]  = addr_m[g];
    assign Htrans_M[g*2 +: 2]   = trans_m[g];
    assign Hwrite_M[g]          = write_m[g];
    assign Hsize_M[g*3 +: 3]    = size_m[g];
    assign Hburst_M[g*3 +: 3]   = burst_m[g];
    assign Hwdata_M[g*DW +: DW] = wdata_m[g];
  end

  master_to_slave_mux #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hmaster(Hmaster),
    .Haddr_M(Haddr_M), .Htrans_M(Htrans_M), .Hwrite_M(Hwrite_M),
    .Hsize_M(Hsize_M), .Hburst_M(Hburst_M), .Hwdata_M(Hwdata_M), .Hready(Hready),
    .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize), .Hburst(Hburst),
    .Hwdata(Hwdata), .Hmaster_data(Hmaster_data), .data_active(data_active),
    .data_write(data_write), .beat_idx(beat_idx), .burst_last(burst_last),
    .seq_err(seq_err)
  );

  always #5 Hclk = ~Hclk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural view of the bus: who owns the data phase and how far the open burst has run.
  int m_owner;
  bit m_dactive, m_dwrite, m_open, m_err;
  int m_done, m_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int beats_of(input logic [2:0] b);
    if (b == 3'd0) return 1;
    if (b == 3'd1) return 0;
    if (b <= 3'd3) return 4;
    if (b <= 3'd5) return 8;
    return 16;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_dactive = 0; m_dwrite = 0;
    m_open = 0; m_err = 0; m_done = 0; m_len = 0;
  endtask

  function automatic bit exp_last_now(input int cur);
    int idx, len;
    idx = (trans_m[cur] == 2'b10) ? 0 : m_done;
    len = (trans_m[cur] == 2'b10) ? beats_of(burst_m[cur]) : m_len;
    return trans_m[cur][1] && (len != 0) && (idx == len - 1);
  endfunction

  task automatic check_all();
    int cur;
    logic [1:0] tr;
    cur = int'(Hmaster);
    tr  = trans_m[cur];
    check("haddr", Haddr, addr_m[cur]);
    check("htrans", Htrans, tr);
    check("hwrite", Hwrite, write_m[cur]);
    check("hsize", Hsize, size_m[cur]);
    check("hburst", Hburst, burst_m[cur]);
    check("hwdata", Hwdata, (m_dactive && m_dwrite) ? wdata_m[m_owner] : '0);
    check("hmaster_data", Hmaster_data, m_owner);
    check("data_active", data_active, m_dactive);
    check("data_write", data_write, m_dwrite);
    check("beat_idx", beat_idx, (tr == 2'b10) ? 0 : m_done);
    check("burst_last", burst_last, exp_last_now(cur));
    check("seq_err", seq_err, m_err);
  endtask

  task automatic model_edge();
    int cur, blen;
    logic [1:0] tr;
    bit last, err;
    cur  = int'(Hmaster);
    tr   = trans_m[cur];
    last = exp_last_now(cur);
    err  = ((tr == 2'b11 || tr == 2'b01) && !m_open) ||
           (tr == 2'b11 && m_len != 0 && m_done >= m_len);
    m_err = Hready && err;
    if (Hready) begin
      m_owner   = cur;
      m_dactive = tr[1];
      m_dwrite  = write_m[cur] && tr[1];
      if (tr == 2'b10) begin
        blen = beats_of(burst_m[cur]);
        m_done = 1; m_len = blen; m_open = (blen != 1);
      end else if (tr == 2'b11) begin
        if (last) m_open = 0;
        m_done = (m_done >= 31) ? 31 : m_done + 1;
      end else if (tr == 2'b00) begin
        m_done = 0; m_open = 0;
      end
    end
  endtask

  // Inputs are set at posedge+1; outputs checked at posedge+2, then the edge is taken.
  task automatic step();
    #1;
    check_all();
    model_edge();
    @(posedge Hclk);
    #1;
  endtask

  task automatic set_m(input int m, input logic [31:0] a, input logic [1:0] t,
                       input logic w, input logic [2:0] b, input logic [31:0] d);
    addr_m[m] = a; trans_m[m] = t; write_m[m] = w;
    size_m[m] = 3'b010; burst_m[m] = b; wdata_m[m] = d;
  endtask

  typedef struct {
    logic [1:0] trans;
    logic [4:0] exp_idx;
    logic       exp_last;
    logic       exp_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // M3 INCR4 with a BUSY, a stray 5th SEQ, then a SEQ with no burst open.
    tbl[0]  = '{2'b10, 5'd0, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 5'd1, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 5'd2, 1'b0, 1'b0};
    tbl[3]  = '{2'b11, 5'd2, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 5'd3, 1'b1, 1'b0};
    tbl[5]  = '{2'b11, 5'd4, 1'b0, 1'b0};
    tbl[6]  = '{2'b00, 5'd5, 1'b0, 1'b1};
    tbl[7]  = '{2'b00, 5'd0, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 5'd0, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 5'd1, 1'b0, 1'b1};
    tbl[10] = '{2'b00, 5'd0, 1'b0, 1'b0};

    Hresetn = 1'b0;
    Hready  = 1'b1;
    Hmaster = '0;
    for (int i = 0; i < NM; i++) set_m(i, 32'h0, 2'b00, 1'b0, 3'b000, 32'h0);
    model_reset();
    #2;
    check("rst_hmaster_data", Hmaster_data, 0);
    check("rst_data_active", data_active, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_hwdata", Hwdata, 0);
    check_all();
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(posedge Hclk);
    #1;

    // 1: M1 NONSEQ write; address same cycle, data owner next cycle.
    Hmaster = 2'd1;
    set_m(1, 32'h100, 2'b10, 1'b1, 3'b000, 32'hA5A5_A5A5);
    #1;
    check("t1_haddr", Haddr, 32'h100);
    step();
    trans_m[1] = 2'b00;
    check("t1_owner", Hmaster_data, 1);
    check("t1_dactive", data_active, 1);
    check("t1_hwdata", Hwdata, 32'hA5A5_A5A5);
    step();

    // 2: M0 write, then grant to M2 IDLE held off by two wait states.
    Hmaster = 2'd0;
    set_m(0, 32'h200, 2'b10, 1'b1, 3'b000, 32'h1111_2222);
    step();
    Hmaster = 2'd2;
    set_m(2, 32'h300, 2'b00, 1'b0, 3'b000, 32'h0);
    Hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("t2_wait_owner", Hmaster_data, 0);
      check("t2_wait_hwdata", Hwdata, 32'h1111_2222);
      step();
    end
    Hready = 1'b1;
    check("t2_hold_hwdata", Hwdata, 32'h1111_2222);
    step();
    check("t2_owner", Hmaster_data, 2);
    check("t2_hwdata", Hwdata, 0);

    // 3/4: burst table on M3.
    Hmaster = 2'd3;
    set_m(3, 32'h400, 2'b00, 1'b0, 3'b011, 32'hCAFE_0003);
    step();
    for (int i = 0; i < 11; i++) begin
      trans_m[3] = tbl[i].trans;
      addr_m[3]  = 32'h400 + 32'(4 * i);
      #1;
      check($sformatf("tbl%0d_beat_idx", i), beat_idx, tbl[i].exp_idx);
      check($sformatf("tbl%0d_burst_last", i), burst_last, tbl[i].exp_last);
      check($sformatf("tbl%0d_seq_err", i), seq_err, tbl[i].exp_err);
      check($sformatf("tbl%0d_htrans", i), Htrans, tbl[i].trans);
      step();
    end

    // 5: INCR of 20 beats never flags a last beat.
    Hmaster = 2'd0;
    set_m(0, 32'h1000, 2'b10, 1'b0, 3'b001, 32'h0);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) trans_m[0] = 2'b11;
      addr_m[0] = 32'h1000 + 32'(4 * i);
      #1;
      check("t5_beat_idx", beat_idx, i);
      check("t5_burst_last", burst_last, 0);
      step();
    end
    trans_m[0] = 2'b00;
    step();

    // 6: async reset mid-INCR8, then a SEQ with nothing open.
    Hmaster = 2'd1;
    set_m(1, 32'h2000, 2'b10, 1'b1, 3'b101, 32'h5A5A_0001);
    step();
    trans_m[1] = 2'b11;
    step();
    step();
    #2;
    Hresetn = 1'b0;
    #1;
    check("t6_owner", Hmaster_data, 0);
    check("t6_dactive", data_active, 0);
    check("t6_dwrite", data_write, 0);
    check("t6_hwdata", Hwdata, 0);
    check("t6_beat_idx", beat_idx, 0);
    check("t6_burst_last", burst_last, 0);
    model_reset();
    #1;
    Hresetn = 1'b1;
    step();
    check("t6_seq_err", seq_err, 1);
    check("t6_htrans", Htrans, 2'b11);
    trans_m[1] = 2'b00;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int r;
      Hmaster = MW'($urandom_range(0, NM - 1));
      Hready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NM; i++) begin
        r = $urandom_range(0, 9);
        addr_m[i]  = $urandom;
        trans_m[i] = (r < 2) ? 2'b00 : (r == 2) ? 2'b01 : (r < 5) ? 2'b10 : 2'b11;
        write_m[i] = 1'($urandom_range(0, 1));
        size_m[i]  = 3'($urandom_range(0, 7));
        burst_m[i] = 3'($urandom_range(0, 7));
        wdata_m[i] = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
